timer_irq: RTL

Memory-mapped 16-bit timer/compare peripheral on the CPU data/IO bus. It decodes a window in the IO region (0x10xx), is programmed through byte registers, and raises a level interrupt on the CPU's `interrupt_N` input. The interrupt is cleared by the CPU's matching `interrupt_N_clr` pulse or by a software write to the status register. It is the producer of one CPU interrupt line and a consumer of CPU bus cycles.

---
 rtl/timer_irq_pkg.sv | 24 ++
 rtl/timer_irq_if.sv | 20 ++
 rtl/timer_irq_prescaler.sv | 29 ++
 rtl/timer_irq.sv | 113 +++++++++++
 4 files changed

// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer_irq peripheral: register offsets and bit positions.
package timer_irq_pkg;

    typedef enum logic [2:0] {
        TMR_CTRL   = 3'd0,
        TMR_PRE    = 3'd1,
        TMR_CMP_L  = 3'd2,
        TMR_CMP_H  = 3'd3,
        TMR_CNT_L  = 3'd4,
        TMR_CNT_H  = 3'd5,
        TMR_STATUS = 3'd6,
        TMR_RSVD   = 3'd7
    } tmr_reg_e;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_IE      = 1;
    localparam int unsigned CTRL_CLR     = 2;
    localparam int unsigned STATUS_MATCH = 0;

    function automatic logic [7:0] ctrl_to_byte(input logic [2:0] ctrl);
        return {5'b0_0000, ctrl};
    endfunction

endpackage

// File: rtl/timer_irq_if.sv
// CPU data/IO bus and interrupt line as seen by the timer peripheral.
interface timer_irq_if;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic        write_en;
    logic        read_en;
    logic [7:0]  data_out;
    logic        interrupt;
    logic        interrupt_clr;

    modport master (
        output address, data_in, write_en, read_en, interrupt_clr,
        input  data_out, interrupt
    );

    modport slave (
        input  address, data_in, write_en, read_en, interrupt_clr,
        output data_out, interrupt
    );
endinterface

// File: rtl/timer_irq_prescaler.sv
// Prescaler: ticks once every pre+1 clocks while enabled; held at 0 when disabled or restarted.
module timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] pre,
    input  logic       restart,
    output logic       tick
);
    logic [7:0] pcnt_q, pcnt_d;

    // Equality compare: a PRE lowered below pcnt lets pcnt wrap through 255 first.
    assign tick = en && (pcnt_q == pre);

    always_comb begin
        pcnt_d = pcnt_q + 8'd1;
        if (!en || restart || tick) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end
endmodule

// File: rtl/timer_irq.sv
// Memory-mapped 16-bit timer/compare peripheral with level interrupt.
module timer_irq
    import timer_irq_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h1010
) (
    input  logic        clk,
    input  logic        reset,
    timer_irq_if.slave  bus
);
    logic [2:0]  ctrl_q, ctrl_d;
    logic [7:0]  pre_q, pre_d;
    logic [15:0] cmp_q, cmp_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  shadow_q, shadow_d;
    logic        match_q, match_d;
    logic [7:0]  dout_q, dout_d;

    logic        sel, wr, rd, cnt_wr, tick, hit, sw_clr;
    logic [7:0]  rdata;
    tmr_reg_e    offs;

    assign sel    = (bus.address[15:3] == BASE_ADDR[15:3]);
    assign wr     = sel && bus.write_en;
    assign rd     = sel && bus.read_en;
    assign offs   = tmr_reg_e'(bus.address[2:0]);
    assign cnt_wr = wr && (offs == TMR_CNT_L);
    assign sw_clr = wr && (offs == TMR_STATUS) && bus.data_in[STATUS_MATCH];
    // A CNT_L write on the matching tick suppresses the match.
    assign hit    = tick && (count_q == cmp_q) && !cnt_wr;

    timer_prescaler u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (ctrl_q[CTRL_EN]),
        .pre     (pre_q),
        .restart (cnt_wr),
        .tick    (tick)
    );

    always_comb begin
        rdata = '0;
        case (offs)
            TMR_CTRL:   rdata = ctrl_to_byte(ctrl_q);
            TMR_PRE:    rdata = pre_q;
            TMR_CMP_L:  rdata = cmp_q[7:0];
            TMR_CMP_H:  rdata = cmp_q[15:8];
            TMR_CNT_L:  rdata = count_q[7:0];
            TMR_CNT_H:  rdata = shadow_q;
            TMR_STATUS: rdata[STATUS_MATCH] = match_q;
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        pre_d    = pre_q;
        cmp_d    = cmp_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        match_d  = match_q;
        dout_d   = rd ? rdata : '0;

        if (wr) begin
            case (offs)
                TMR_CTRL:  ctrl_d      = bus.data_in[2:0];
                TMR_PRE:   pre_d       = bus.data_in;
                TMR_CMP_L: cmp_d[7:0]  = bus.data_in;
                TMR_CMP_H: cmp_d[15:8] = bus.data_in;
                default:   ;
            endcase
        end

        if (rd && (offs == TMR_CNT_L)) begin
            shadow_d = count_q[15:8];
        end

        if (cnt_wr) begin
            count_d = '0;
        end else if (tick) begin
            count_d = (hit && ctrl_q[CTRL_CLR]) ? '0 : count_q + 16'd1;
        end

        if (hit) begin
            match_d = 1'b1;
        end else if (sw_clr || bus.interrupt_clr) begin
            match_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q   <= '0;
            pre_q    <= '0;
            cmp_q    <= '0;
            count_q  <= '0;
            shadow_q <= '0;
            match_q  <= 1'b0;
            dout_q   <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            pre_q    <= pre_d;
            cmp_q    <= cmp_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            match_q  <= match_d;
            dout_q   <= dout_d;
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.interrupt = match_q & ctrl_q[CTRL_IE];
endmodule
